pipeline_hazard_controller: RTL and testbench

Stall/flush sequencer for the pipelined MIPS core. It watches the ID, EX and MEM stages and drives the enables and flushes of the PC and the IF/ID register, plus a bubble into ID/EX. It also drives a hold for the EX/MEM/WB registers during multi-cycle data-memory accesses. It resolves load-use hazards, taken branch/jump redirects and memory wait states, and keeps saturating stall and flush counters for performance.

---
 rtl/pipeline_hazard_controller_if.sv | 30 +++
 rtl/pipeline_hazard_controller.sv | 77 +++++++
 tb/tb_pipeline_hazard_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: hazard inputs and pipeline control outputs of the stall/flush sequencer
interface pipeline_hazard_controller_if #(parameter int CNT_WIDTH = 16);
  logic [4:0]           id_rs_i;
  logic [4:0]           id_rt_i;
  logic                 id_uses_rt_i;
  logic                 ex_mem_read_i;
  logic [4:0]           ex_rt_i;
  logic                 id_branch_taken_i;
  logic                 id_jump_i;
  logic                 mem_access_i;
  logic                 pc_enable_o;
  logic                 ifid_enable_o;
  logic                 ifid_flush_o;
  logic                 idex_bubble_o;
  logic                 pipe_hold_o;
  logic [CNT_WIDTH-1:0] stall_count_o;
  logic [CNT_WIDTH-1:0] flush_count_o;
  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
           id_branch_taken_i, id_jump_i, mem_access_i,
    input  pc_enable_o, ifid_enable_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           stall_count_o, flush_count_o
  );
  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_rt_i,
           id_branch_taken_i, id_jump_i, mem_access_i,
    output pc_enable_o, ifid_enable_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
           stall_count_o, flush_count_o
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, branch/jump flush and data-memory wait sequencing
// with saturating stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int MEM_WAIT_CYCLES = 0,
  parameter int CNT_WIDTH       = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_controller_if.slave hz
);
  localparam int WW = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] LOAD_CNT = WW'((MEM_WAIT_CYCLES > 1) ? MEM_WAIT_CYCLES - 2 : 0);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_DONE} state_t;

  state_t               r_state, w_state_nx;
  logic [WW-1:0]        r_wait_cnt, w_wait_nx;
  logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
  logic                 w_lu, w_rd, w_hold;
  logic                 w_pc_en, w_ifid_en, w_flush, w_bubble;

  assign w_lu = hz.ex_mem_read_i & (hz.ex_rt_i != 5'd0) &
                ((hz.ex_rt_i == hz.id_rs_i) | (hz.id_uses_rt_i & (hz.ex_rt_i == hz.id_rt_i)));
  assign w_rd = hz.id_branch_taken_i | hz.id_jump_i;
  // The RUN cycle that sees the access is itself the first hold cycle, so N holds
  // are the entry cycle plus N-1 MEM_WAIT cycles.
  assign w_hold = (r_state == MEM_WAIT) |
                  ((r_state == RUN) & hz.mem_access_i & (MEM_WAIT_CYCLES > 0));

  always_comb begin
    w_pc_en    = 1'b1;
    w_ifid_en  = 1'b1;
    w_flush    = 1'b0;
    w_bubble   = 1'b0;
    w_state_nx = RUN;
    w_wait_nx  = r_wait_cnt;
    if (w_hold) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      if (r_state == RUN) begin
        w_state_nx = (MEM_WAIT_CYCLES > 1) ? MEM_WAIT : MEM_DONE;
        w_wait_nx  = LOAD_CNT;
      end else begin
        w_state_nx = (r_wait_cnt == '0) ? MEM_DONE : MEM_WAIT;
        w_wait_nx  = (r_wait_cnt == '0) ? r_wait_cnt : r_wait_cnt - 1'b1;
      end
    end else if (w_lu) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      w_bubble  = 1'b1;
    end else if (w_rd) begin
      w_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_wait_cnt  <= w_wait_nx;
      if (!w_pc_en && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.pc_enable_o   = reset & w_pc_en;
  assign hz.ifid_enable_o = reset & w_ifid_en;
  assign hz.ifid_flush_o  = reset & w_flush;
  assign hz.idex_bubble_o = reset & w_bubble;
  assign hz.pipe_hold_o   = reset & w_hold;
  assign hz.stall_count_o = r_stall_cnt;
  assign hz.flush_count_o = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks of a 2-cycle-wait/4-bit-counter instance
// and a zero-wait instance sharing the same hazard inputs.
module tb_pipeline_hazard_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] HOLD  = 5'b00001;

  pipeline_hazard_controller_if #(.CNT_WIDTH(4))  ifa ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(16)) ifb ();

  pipeline_hazard_controller #(.MEM_WAIT_CYCLES(2), .CNT_WIDTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .hz(ifa.slave));
  pipeline_hazard_controller #(.MEM_WAIT_CYCLES(0), .CNT_WIDTH(16)) u_dut_b (
    .clk(clk), .reset(reset), .hz(ifb.slave));

  assign ifb.id_rs_i           = ifa.id_rs_i;
  assign ifb.id_rt_i           = ifa.id_rt_i;
  assign ifb.id_uses_rt_i      = ifa.id_uses_rt_i;
  assign ifb.ex_mem_read_i     = ifa.ex_mem_read_i;
  assign ifb.ex_rt_i           = ifa.ex_rt_i;
  assign ifb.id_branch_taken_i = ifa.id_branch_taken_i;
  assign ifb.id_jump_i         = ifa.id_jump_i;
  assign ifb.mem_access_i      = ifa.mem_access_i;

  always #5 clk = ~clk;

  wire [4:0] w_ctl_a = {ifa.pc_enable_o, ifa.ifid_enable_o, ifa.ifid_flush_o, ifa.idex_bubble_o, ifa.pipe_hold_o};
  wire [4:0] w_ctl_b = {ifb.pc_enable_o, ifb.ifid_enable_o, ifb.ifid_flush_o, ifb.idex_bubble_o, ifb.pipe_hold_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic rd_ld, input logic [4:0] ext, input logic br,
                       input logic j, input logic mem);
    ifa.id_rs_i           = rs;
    ifa.id_rt_i           = rt;
    ifa.id_uses_rt_i      = uses;
    ifa.ex_mem_read_i     = rd_ld;
    ifa.ex_rt_i           = ext;
    ifa.id_branch_taken_i = br;
    ifa.id_jump_i         = j;
    ifa.mem_access_i      = mem;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ctl_a", 32'(w_ctl_a), 0);
    chk("rst_stall_a", 32'(ifa.stall_count_o), 0);
    chk("rst_flush_b", 32'(ifb.flush_count_o), 0);
    step();
    reset = 1'b1;
    #1;
    chk("idle_ctl_a", 32'(w_ctl_a), 32'(IDLE));
    drive(8, 0, 0, 1, 8, 0, 0, 0);
    chk("lu_rs_ctl", 32'(w_ctl_a), 32'(STALL));
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_rs_one_cycle", 32'(w_ctl_a), 32'(IDLE));
    chk("lu_rs_stall_cnt", 32'(ifa.stall_count_o), 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("r0_no_stall", 32'(w_ctl_a), 32'(IDLE));
    drive(3, 9, 0, 1, 9, 0, 0, 0);
    chk("rt_unused_no_stall", 32'(w_ctl_a), 32'(IDLE));
    drive(3, 9, 1, 1, 9, 0, 0, 0);
    chk("rt_used_stall", 32'(w_ctl_a), 32'(STALL));
    step();
    chk("rt_stall_cnt", 32'(ifa.stall_count_o), 2);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("beq_flush", 32'(w_ctl_a), 32'(FLUSH));
    step();
    chk("beq_flush_cnt", 32'(ifa.flush_count_o), 1);
    drive(8, 0, 0, 1, 8, 1, 0, 0);
    chk("lu_beats_beq", 32'(w_ctl_a), 32'(STALL));
    step();
    chk("lu_beats_flush_cnt", 32'(ifa.flush_count_o), 1);
    chk("lu_beats_stall_cnt", 32'(ifa.stall_count_o), 3);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("jump_flush_b", 32'(w_ctl_b), 32'(FLUSH));
    step();
    chk("jump_flush_cnt_a", 32'(ifa.flush_count_o), 2);
    chk("jump_flush_cnt_b", 32'(ifb.flush_count_o), 2);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("mem_hold1_a", 32'(w_ctl_a), 32'(HOLD));
    chk("mem_nowait_b", 32'(w_ctl_b), 32'(IDLE));
    step();
    chk("mem_hold2_a", 32'(w_ctl_a), 32'(HOLD));
    drive(8, 0, 0, 1, 8, 0, 0, 1);
    chk("mem_hold_ignores_lu", 32'(w_ctl_a), 32'(HOLD));
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("mem_done_a", 32'(w_ctl_a), 32'(IDLE));
    chk("mem_stall_cnt", 32'(ifa.stall_count_o), 5);
    chk("mem_b_stall_cnt", 32'(ifb.stall_count_o), 3);
    step();
    chk("b2b_new_wait", 32'(w_ctl_a), 32'(HOLD));
    step();
    chk("b2b_hold2", 32'(w_ctl_a), 32'(HOLD));
    reset = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'(w_ctl_a), 0);
    chk("rst_mid_stall", 32'(ifa.stall_count_o), 0);
    chk("rst_mid_flush", 32'(ifa.flush_count_o), 0);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_hold1", 32'(w_ctl_a), 32'(HOLD));
    step();
    chk("post_rst_hold2", 32'(w_ctl_a), 32'(HOLD));
    step();
    chk("post_rst_done", 32'(w_ctl_a), 32'(IDLE));
    chk("post_rst_stall", 32'(ifa.stall_count_o), 2);
    drive(8, 0, 0, 1, 8, 0, 0, 0);
    for (int i = 0; i < 12; i++) step();
    chk("sat_pre_a", 32'(ifa.stall_count_o), 14);
    for (int i = 0; i < 8; i++) step();
    chk("sat_a", 32'(ifa.stall_count_o), 15);
    chk("sat_b", 32'(ifb.stall_count_o), 20);
    chk("sat_ctl_a", 32'(w_ctl_a), 32'(STALL));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
